// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD timing generator: pattern modes, colour-bar
// palette and the default 320x240 panel timing.
package lcd_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_HBAND = 2'd1,
    MODE_VBAR  = 2'd2,
    MODE_CHECK = 2'd3
  } lcd_mode_e;

  // {r,g,b} on/off per palette index; each bit expands to a full-scale channel.
  localparam logic [2:0] PALETTE [8] = '{
    3'b111,  // white
    3'b110,  // yellow
    3'b011,  // cyan
    3'b010,  // green
    3'b101,  // magenta
    3'b100,  // red
    3'b001,  // blue
    3'b000   // black
  };

  localparam int LCD_H_PERIOD = 429;
  localparam int LCD_H_PWIDTH = 11;
  localparam int LCD_H_BPORCH = 42;
  localparam int LCD_H_ACTIVE = 320;
  localparam int LCD_V_PERIOD = 262;
  localparam int LCD_V_PWIDTH = 3;
  localparam int LCD_V_BPORCH = 7;
  localparam int LCD_V_ACTIVE = 240;

endpackage

// File: rtl/lcd_pattern_gen.sv
// Built-in test-pattern colour for the current pixel. Band indices come from
// running sub-counters restarted at the first active pixel/line (no divider).
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int CW        = 6,
  parameter int CNT_W     = 10,
  parameter int H_ACTIVE  = LCD_H_ACTIVE,
  parameter int V_ACTIVE  = LCD_V_ACTIVE,
  parameter int CHK_SHIFT = 4
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            h_act,
  input  logic            v_act,
  input  logic            h_first,
  input  logic            v_first,
  input  logic            line_end,
  input  logic [CNT_W-1:0] px_x,
  input  logic [CNT_W-1:0] px_y,
  input  lcd_mode_e       mode,
  input  logic [3*CW-1:0] solid_rgb,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b
);

  localparam logic [CNT_W-1:0] H_STEP_LAST = CNT_W'(H_ACTIVE / 8 - 1);
  localparam logic [CNT_W-1:0] V_STEP_LAST = CNT_W'(V_ACTIVE / 8 - 1);

  logic [CNT_W-1:0] hsub_q, vsub_q, hsub_cur, vsub_cur;
  logic [2:0]       hband_q, vband_q, hband_cur, vband_cur;
  logic [2:0]       pal;
  logic [3*CW-1:0]  rgb;
  logic             coord_unused;

  // The first active pixel/line restarts its band from zero.
  assign hsub_cur  = h_first ? '0 : hsub_q;
  assign hband_cur = h_first ? '0 : hband_q;
  assign vsub_cur  = v_first ? '0 : vsub_q;
  assign vband_cur = v_first ? '0 : vband_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hsub_q  <= '0;
      hband_q <= '0;
      vsub_q  <= '0;
      vband_q <= '0;
    end else begin
      if (h_act) begin
        if (hsub_cur == H_STEP_LAST) begin
          hsub_q  <= '0;
          hband_q <= (hband_cur == 3'd7) ? 3'd7 : hband_cur + 3'd1;
        end else begin
          hsub_q  <= hsub_cur + CNT_W'(1);
          hband_q <= hband_cur;
        end
      end
      if (line_end && v_act) begin
        if (vsub_cur == V_STEP_LAST) begin
          vsub_q  <= '0;
          vband_q <= (vband_cur == 3'd7) ? 3'd7 : vband_cur + 3'd1;
        end else begin
          vsub_q  <= vsub_cur + CNT_W'(1);
          vband_q <= vband_cur;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    pal = PALETTE[7];
    rgb = '0;
    case (mode)
      MODE_HBAND: pal = PALETTE[vband_cur];
      MODE_VBAR:  pal = PALETTE[hband_cur];
      MODE_CHECK: pal = (px_x[CHK_SHIFT] ^ px_y[CHK_SHIFT]) ? PALETTE[0] : PALETTE[7];
      default:    pal = PALETTE[7];
    endcase
    if (mode == MODE_SOLID) rgb = solid_rgb;
    else                    rgb = {{CW{pal[2]}}, {CW{pal[1]}}, {CW{pal[0]}}};
  end

  assign {r, g, b} = rgb;

  // Only the checker bit of each coordinate matters here.
  assign coord_unused = ^{px_x, px_y};

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised parallel RGB LCD timing generator: HSYNC/VSYNC/DE, active-area
// coordinates, frame-start strobe and a frame-latched test pattern.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int CW        = 6,
  parameter int CNT_W     = 10,
  parameter int H_PERIOD  = LCD_H_PERIOD,
  parameter int H_PWIDTH  = LCD_H_PWIDTH,
  parameter int H_BPORCH  = LCD_H_BPORCH,
  parameter int H_ACTIVE  = LCD_H_ACTIVE,
  parameter int V_PERIOD  = LCD_V_PERIOD,
  parameter int V_PWIDTH  = LCD_V_PWIDTH,
  parameter int V_BPORCH  = LCD_V_BPORCH,
  parameter int V_ACTIVE  = LCD_V_ACTIVE,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CHK_SHIFT = 4
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [3*CW-1:0]  solid_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CW-1:0]    r,
  output logic [CW-1:0]    g,
  output logic [CW-1:0]    b,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             frame_start
);

  if (H_PWIDTH >= H_PERIOD) begin : g_bad_hpw
    $error("H_PWIDTH must be less than H_PERIOD");
  end
  if (H_BPORCH + H_ACTIVE > H_PERIOD) begin : g_bad_hact
    $error("H_BPORCH + H_ACTIVE exceeds H_PERIOD");
  end
  if (V_BPORCH + V_ACTIVE > V_PERIOD) begin : g_bad_vact
    $error("V_BPORCH + V_ACTIVE exceeds V_PERIOD");
  end
  if (H_ACTIVE < 8 || V_ACTIVE < 8) begin : g_bad_small
    $error("H_ACTIVE and V_ACTIVE must be at least 8");
  end
  if (H_PERIOD > 2**CNT_W || V_PERIOD > 2**CNT_W || CHK_SHIFT >= CNT_W) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the panel timing");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_PERIOD - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_PERIOD - 1);
  localparam logic [CNT_W-1:0] H_PW   = CNT_W'(H_PWIDTH);
  localparam logic [CNT_W-1:0] V_PW   = CNT_W'(V_PWIDTH);
  localparam logic [CNT_W-1:0] H_BP   = CNT_W'(H_BPORCH);
  localparam logic [CNT_W-1:0] V_BP   = CNT_W'(V_BPORCH);
  localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_BPORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_BPORCH + V_ACTIVE);

  logic [CNT_W-1:0] hc, vc, x_cur, y_cur;
  logic             line_end, frame_end, h_act, v_act, act, frame_first;
  lcd_mode_e        mode_q;
  logic [3*CW-1:0]  solid_q;
  logic [CW-1:0]    pat_r, pat_g, pat_b;

  assign line_end    = (hc == H_LAST);
  assign frame_end   = (vc == V_LAST);
  assign h_act       = (hc >= H_BP) && (hc < H_END);
  assign v_act       = (vc >= V_BP) && (vc < V_END);
  assign act         = h_act && v_act;
  assign x_cur       = act ? hc - H_BP : '0;
  assign y_cur       = act ? vc - V_BP : '0;
  assign frame_first = (hc == '0) && (vc == '0);

  always_ff @(posedge clk or negedge res_n) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!res_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!enable) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= line_end ? '0 : hc + CNT_W'(1);
      if (line_end) vc <= frame_end ? '0 : vc + CNT_W'(1);
    end
  end

  lcd_pattern_gen #(
    .CW        (CW),
    .CNT_W     (CNT_W),
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .CHK_SHIFT (CHK_SHIFT)
  ) u_pattern (
    .clk       (clk),
    .res_n     (res_n),
    .h_act     (h_act),
    .v_act     (v_act),
    .h_first   (hc == H_BP),
    .v_first   (vc == V_BP),
    .line_end  (line_end),
    .px_x      (x_cur),
    .px_y      (y_cur),
    .mode      (mode_q),
    .solid_rgb (solid_q),
    .r         (pat_r),
    .g         (pat_g),
    .b         (pat_b)
  );

  // Outputs are one register stage behind (hc,vc); pattern settings change only at frame start.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
      mode_q      <= MODE_SOLID;
      solid_q     <= '0;
    end else if (!enable) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (hc < H_PW) ? HS_POL : ~HS_POL;
      vsync       <= (vc < V_PW) ? VS_POL : ~VS_POL;
      de          <= act;
      r           <= act ? pat_r : '0;
      g           <= act ? pat_g : '0;
      b           <= act ? pat_b : '0;
      px_x        <= x_cur;
      px_y        <= y_cur;
      frame_start <= frame_first;
      if (frame_first) begin
        mode_q  <= lcd_mode_e'(mode);
        solid_q <= solid_rgb;
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: default horizontal timing, a short
// 36-line frame so several frames fit in a short run.
module tb_lcd_timing_gen;

  localparam int CW = 6;
  localparam int CNT_W = 10;
  // Frame = 429 * 36 = 15444 clocks; active line at vc=7 starts at 7*429 = 3003.
  localparam int F = 15444;
  localparam logic [17:0] WHITE  = 18'h3FFFF;
  localparam logic [17:0] YELLOW = 18'h3FFC0;
  localparam logic [17:0] BLACK  = 18'h00000;
  localparam logic [17:0] SOLID  = 18'h15A85;  // {15,2A,05}

  logic             clk = 1'b0;
  logic             res_n;
  logic             enable;
  logic [1:0]       mode;
  logic [3*CW-1:0]  solid_rgb;
  logic             hsync, vsync, de, frame_start;
  logic [CW-1:0]    r, g, b;
  logic [CNT_W-1:0] px_x, px_y;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int hs_low, vs_low, de_cnt, fs_cnt, first_de, rel;
  logic [17:0] cap0, cap1, cap2, cap3;
  logic        cap_de;

  lcd_timing_gen #(
    .CW(CW), .CNT_W(CNT_W),
    .H_PERIOD(429), .H_PWIDTH(11), .H_BPORCH(42), .H_ACTIVE(320),
    .V_PERIOD(36), .V_PWIDTH(3), .V_BPORCH(7), .V_ACTIVE(24),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHK_SHIFT(4)
  ) dut (
    .clk(clk), .res_n(res_n), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .px_x(px_x), .px_y(px_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    res_n = 1'b0; enable = 1'b0; mode = 2'd2; solid_rgb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_de", de, 0);
    check("rst_fs", frame_start, 0);
    check("rst_rgb", {r, g, b}, 0);
    check("rst_px", {px_x, px_y}, 0);

    @(negedge clk) res_n = 1'b1;
    tick(); tick();
    check("idle_fs", frame_start, 0);
    check("idle_hsync", hsync, 1);

    // Frame 0, vertical bars
    enable = 1'b1;
    tick(); cyc = 0;
    check("f0_fs", frame_start, 1);
    check("f0_hsync0", hsync, 0);
    check("f0_vsync0", vsync, 0);
    check("f0_de0", de, 0);
    tick();
    check("f0_fs_pulse", frame_start, 0);
    step_to(10);   check("hs_last_low", hsync, 0);
    step_to(11);   check("hs_first_high", hsync, 1);
    step_to(1286); check("vs_last_low", vsync, 0);
    step_to(1287); check("vs_first_high", vsync, 1);
    step_to(3044); check("pre_de", de, 0); check("pre_de_rgb", {r, g, b}, 0);
    step_to(3045);
    check("first_de", de, 1);
    check("first_px", {px_x, px_y}, 0);
    check("vbar_x0", {r, g, b}, WHITE);
    step_to(3084); check("vbar_x39_px", px_x, 39); check("vbar_x39", {r, g, b}, WHITE);
    step_to(3085); check("vbar_x40_px", px_x, 40); check("vbar_x40", {r, g, b}, YELLOW);
    step_to(3325); check("vbar_x280_px", px_x, 280); check("vbar_x280", {r, g, b}, BLACK);
    check("vbar_x280_de", de, 1);
    step_to(3364); check("x319_px", px_x, 319); check("x319_de", de, 1);
    step_to(3365); check("post_de", de, 0); check("post_de_px", px_x, 0);

    // Line vc=8 census
    step_to(3431);
    hs_low = 0; de_cnt = 0; first_de = -1;
    for (int i = 0; i < 429; i++) begin
      tick();
      if (!hsync) hs_low++;
      if (de) begin
        if (de_cnt == 0) first_de = cyc - 3432;
        de_cnt++;
      end
    end
    check("line_hs_low", hs_low, 11);
    check("line_de_cnt", de_cnt, 320);
    check("line_de_start", first_de, 42);

    mode = 2'd3;  // takes effect at frame 1

    // Frame 1 census, checker pattern
    step_to(F - 1);
    hs_low = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < F; i++) begin
      tick();
      rel = cyc - F;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (de) de_cnt++;
      if (frame_start) fs_cnt++;
      if (rel == 3045) cap0 = {r, g, b};
      if (rel == 3061) cap1 = {r, g, b};
      if (rel == 9909) cap2 = {r, g, b};
      if (rel == 9925) begin cap3 = {r, g, b}; cap_de = de; end
      if (rel == 5000) mode = 2'd1;
    end
    check("frame_hs_low", hs_low, 396);
    check("frame_vs_low", vs_low, 1287);
    check("frame_de_cnt", de_cnt, 7680);
    check("frame_fs_cnt", fs_cnt, 1);
    check("chk_0_0", cap0, BLACK);
    check("chk_16_0", cap1, WHITE);
    check("chk_0_16", cap2, WHITE);
    check("chk_16_16", cap3, BLACK);
    check("chk_16_16_de", cap_de, 1);

    // Frame 2, horizontal bands; switch to solid mid-frame
    step_to(2*F); check("f2_fs", frame_start, 1);
    step_to(2*F + 3045); check("hband_y0", {r, g, b}, WHITE);
    step_to(2*F + 4390); check("hband_y3_px", px_y, 3); check("hband_y3", {r, g, b}, YELLOW);
    mode = 2'd0; solid_rgb = {6'h15, 6'h2A, 6'h05};
    step_to(2*F + 5348); check("hband_hold_y5", {r, g, b}, YELLOW);
    step_to(2*F + 12912);
    check("hband_y23_px", px_y, 23);
    check("hband_y23_de", de, 1);
    check("hband_y23", {r, g, b}, BLACK);

    // Frame 3, solid colour from the first active pixel
    step_to(3*F + 3044); check("solid_pre", {r, g, b}, 0);
    step_to(3*F + 3045); check("solid_first", {r, g, b}, SOLID);
    step_to(3*F + 9909); check("solid_mid", {r, g, b}, SOLID);
    step_to(3*F + 9950); check("pre_idle_de", de, 1);

    // Drop enable mid-line
    enable = 1'b0;
    tick();
    check("idle_de", de, 0);
    check("idle_hs", hsync, 1);
    check("idle_rgb", {r, g, b}, 0);
    repeat (5) tick();
    check("idle_fs_hold", frame_start, 0);
    check("idle_px", px_x, 0);
    check("idle_vs", vsync, 1);

    // Re-enable: timing restarts from hc=vc=0
    enable = 1'b1;
    tick(); cyc = 0;
    check("reen_fs", frame_start, 1);
    check("reen_hs", hsync, 0);
    check("reen_vs", vsync, 0);
    step_to(10); check("reen_hs10", hsync, 0);
    step_to(11); check("reen_hs11", hsync, 1);
    step_to(3045); check("reen_de", de, 1); check("reen_rgb", {r, g, b}, SOLID);

    // Asynchronous reset mid-frame, no clock edge needed
    #3 res_n = 1'b0;
    #1;
    check("arst_de", de, 0);
    check("arst_hs", hsync, 1);
    check("arst_vs", vsync, 1);
    check("arst_rgb", {r, g, b}, 0);
    check("arst_px", px_x, 0);
    @(negedge clk) res_n = 1'b1;
    tick();
    check("rel_fs", frame_start, 1);
    check("rel_hs", hsync, 0);
    tick();
    check("rel_fs_pulse", frame_start, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
